core_mem_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and load/store. Fetch and the LSU each issue one request at a time. The arbiter accepts one request, runs it to completion on the memory side, and returns the response to its owner. Only one memory transaction is ever outstanding. Data requests have priority; a starvation guard bounds how long fetch can wait.

---
 rtl/core_pkg.sv | 21 ++
 rtl/core_mem_arbiter_if.sv | 52 +++++
 rtl/core_mem_prio.sv | 45 ++++
 rtl/core_mem_arbiter.sv | 119 +++++++++++
 tb/tb_core_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core memory-port arbiter.
package core_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// slave  : the arbiter itself.
// master : the environment (fetch unit, LSU and memory together).
interface core_mem_arbiter_if;
    import core_pkg::*;

    // fetch side
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;

    // load/store side
    logic            d_req;
    logic            d_we;
    logic [BE_W-1:0] d_be;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    // memory side
    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/core_mem_prio.sv
// Winner selection between fetch and data, with a streak counter that
// bounds how many data grants in a row fetch can be passed over.
module core_mem_prio
    import core_pkg::*;
#(
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   gnt_stb,
    output owner_t win
);

    localparam logic [3:0] BURST_MAX = 4'(D_BURST_MAX);

    logic [3:0] streak;

    // Data wins by default; fetch wins a contested pick once the streak is full.
    always_comb begin
        win = OWN_D;
        if (i_req && d_req) begin
            win = (streak == BURST_MAX) ? OWN_I : OWN_D;
        end else if (i_req) begin
            win = OWN_I;
        end
    end

    // Count data grants that made a waiting fetch wait; anything else clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (gnt_stb) begin
            if (win == OWN_D && i_req) begin
                if (streak < BURST_MAX) begin
                    streak <= streak + 4'd1;
                end
            end else begin
                streak <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU.
// One transaction in flight at a time; the response goes back to its owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; grant the winning request combinationally
// ST_ISSUE | MEM_REQ high with latched fields, waiting for MEM_GNT
// ST_WAIT  | request accepted, waiting for MEM_RVALID
// ST_RESP  | owner's RVALID pulse is on the outputs this cycle
module core_mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    core_mem_arbiter_if.slave  bus
);

    state_t          state;
    owner_t          owner;
    owner_t          win;
    logic            gnt_stb;
    logic            capture;
    logic [XLEN-1:0] resp_data;

    assign gnt_stb    = (state == ST_IDLE) && (bus.i_req || bus.d_req);
    assign bus.i_gnt  = gnt_stb && (win == OWN_I);
    assign bus.d_gnt  = gnt_stb && (win == OWN_D);

    // A store has nothing to return, so its response data is forced to zero.
    assign resp_data  = bus.mem_we ? '0 : bus.mem_rdata;

    // Response is taken in WAIT, or in ISSUE only when it arrives together
    // with the grant; stray MEM_RVALID in other states is dropped.
    assign capture    = ((state == ST_ISSUE) && bus.mem_gnt && bus.mem_rvalid) ||
                        ((state == ST_WAIT) && bus.mem_rvalid);

    core_mem_prio #(
        .D_BURST_MAX (D_BURST_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.i_req),
        .d_req   (bus.d_req),
        .gnt_stb (gnt_stb),
        .win     (win)
    );

    // Transaction sequencing, request latching and response return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_I;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rvalid  <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_stb) begin
                        owner       <= win;
                        bus.mem_req <= 1'b1;
                        state       <= ST_ISSUE;
                        if (win == OWN_I) begin
                            bus.mem_we    <= 1'b0;
                            bus.mem_be    <= '1;
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_wdata <= '0;
                        end else begin
                            bus.mem_we    <= bus.d_we;
                            bus.mem_be    <= bus.d_be;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= bus.mem_rvalid ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // RVALID goes out registered, so it is raised on entry to RESP.
            if (capture) begin
                if (owner == OWN_I) begin
                    bus.i_rvalid <= 1'b1;
                    bus.i_rdata  <= resp_data;
                end else begin
                    bus.d_rvalid <= 1'b1;
                    bus.d_rdata  <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with a transaction-level reference model.
module tb_core_mem_arbiter;
    import core_pkg::*;

    localparam int unsigned BMAX = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    core_mem_arbiter_if bus ();

    core_mem_arbiter #(
        .D_BURST_MAX (BMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model: one transaction record plus the starvation streak
    bit          m_busy;
    bit          m_acc;
    bit          m_resp;
    owner_t      m_own;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_ird;
    logic [31:0] m_drd;
    int          m_streak;
    owner_t      gq[$];

    logic        s_i_gnt;
    logic        s_d_gnt;

    // scripted memory responder
    bit          mem_auto;
    int          gnt_wait;
    int          rv_delay;
    int          w_cnt;
    int          pend;
    logic [31:0] rsp_data;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_str(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_resp = 0; m_own = OWN_I;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        m_ird = 0; m_drd = 0; m_streak = 0;
    endtask

    // Compare this cycle's outputs, then advance the model across the edge.
    task automatic model_step();
        owner_t      w;
        bit          resp_n;
        logic [31:0] cap;
        logic        e_ig;
        logic        e_dg;

        w = OWN_D;
        if (bus.i_req && bus.d_req) w = (m_streak == int'(BMAX)) ? OWN_I : OWN_D;
        else if (bus.i_req)         w = OWN_I;
        e_ig = !m_busy && bus.i_req && (w == OWN_I);
        e_dg = !m_busy && bus.d_req && (w == OWN_D);

        s_i_gnt = bus.i_gnt;
        s_d_gnt = bus.d_gnt;
        chk("i_gnt",     32'(bus.i_gnt),    32'(e_ig));
        chk("d_gnt",     32'(bus.d_gnt),    32'(e_dg));
        chk("mem_req",   32'(bus.mem_req),  32'(m_busy && !m_acc));
        chk("mem_we",    32'(bus.mem_we),   32'(m_we));
        chk("mem_be",    32'(bus.mem_be),   32'(m_be));
        chk("mem_addr",  bus.mem_addr,      m_addr);
        chk("mem_wdata", bus.mem_wdata,     m_wdata);
        chk("i_rvalid",  32'(bus.i_rvalid), 32'(m_resp && m_own == OWN_I));
        chk("d_rvalid",  32'(bus.d_rvalid), 32'(m_resp && m_own == OWN_D));
        chk("i_rdata",   bus.i_rdata,       m_ird);
        chk("d_rdata",   bus.d_rdata,       m_drd);

        resp_n = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (e_ig || e_dg) begin
                gq.push_back(w);
                m_busy = 1; m_acc = 0; m_own = w;
                if (w == OWN_I) begin
                    m_we = 0; m_be = 4'hF; m_addr = bus.i_addr; m_wdata = 0;
                end else begin
                    m_we = bus.d_we; m_be = bus.d_be; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                end
                if (w == OWN_D && bus.i_req)
                    m_streak = (m_streak + 1 > int'(BMAX)) ? int'(BMAX) : m_streak + 1;
                else
                    m_streak = 0;
            end
        end else if (m_resp) begin
            m_busy = 0;
        end else if (!m_acc) begin
            if (bus.mem_gnt) begin
                m_acc = 1;
                if (bus.mem_rvalid) resp_n = 1;
            end
        end else if (bus.mem_rvalid) begin
            resp_n = 1;
        end

        if (resp_n) begin
            cap = m_we ? 32'h0 : bus.mem_rdata;
            if (m_own == OWN_I) m_ird = cap;
            else                m_drd = cap;
        end
        m_resp = resp_n;
    endtask

    // One clock: check at the falling edge, then drive memory after the rise.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rsp_data;
                end
            end else if (bus.mem_req) begin
                if (w_cnt < gnt_wait) begin
                    w_cnt++;
                end else begin
                    w_cnt       = 0;
                    bus.mem_gnt = 1'b1;
                    if (rv_delay == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rsp_data;
                    end else begin
                        pend = rv_delay;
                    end
                end
            end
        end
    endtask

    initial begin
        int    cnt_a;
        int    cnt_b;
        int    start;
        string order;

        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        mem_auto = 0; gnt_wait = 0; rv_delay = 0; w_cnt = 0; pend = 0; rsp_data = 0;
        model_reset();

        tick();
        tick();
        rst = 1'b0;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_be",  32'(bus.mem_be),  32'h0);

        // single fetch, no memory wait
        mem_auto = 1; gnt_wait = 0; rv_delay = 1; rsp_data = 32'h0050_0093;
        bus.i_req = 1; bus.i_addr = 32'h100;
        tick();
        chk("fetch_gnt_c0", 32'(s_i_gnt), 32'h1);
        bus.i_req = 0;
        chk("fetch_req_c1",  32'(bus.mem_req), 32'h1);
        chk("fetch_addr_c1", bus.mem_addr,     32'h100);
        chk("fetch_we_c1",   32'(bus.mem_we),  32'h0);
        chk("fetch_be_c1",   32'(bus.mem_be),  32'hF);
        cnt_a = 0;
        for (int k = 0; k < 2; k++) begin
            cnt_a += int'(bus.d_rvalid);
            tick();
        end
        chk("fetch_rvalid_c3", 32'(bus.i_rvalid), 32'h1);
        chk("fetch_rdata_c3",  bus.i_rdata,       32'h0050_0093);
        for (int k = 0; k < 4; k++) begin
            cnt_a += int'(bus.d_rvalid);
            tick();
        end
        chk("fetch_no_d_rvalid", 32'(cnt_a), 32'h0);

        // store with two memory wait cycles before the grant
        gnt_wait = 2; rv_delay = 1; rsp_data = 32'hCAFE_F00D;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store_gnt", 32'(s_d_gnt), 32'h1);
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.mem_req) begin
                cnt_a++;
                chk("store_addr",  bus.mem_addr,      32'h2000);
                chk("store_wdata", bus.mem_wdata,     32'hDEAD_BEEF);
                chk("store_be",    32'(bus.mem_be),   32'h3);
                chk("store_we",    32'(bus.mem_we),   32'h1);
            end
            if (bus.d_rvalid) begin
                cnt_b++;
                chk("store_rdata", bus.d_rdata, 32'h0);
            end
            tick();
        end
        chk("store_req_cycles", 32'(cnt_a), 32'd3);
        chk("store_rvalid_cnt", 32'(cnt_b), 32'd1);

        // both requesters held continuously
        gnt_wait = 0; rv_delay = 0; w_cnt = 0; pend = 0; rsp_data = 32'h5555_AAAA;
        start = gq.size();
        bus.i_req = 1; bus.i_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h500;
        for (int k = 0; k < 200 && gq.size() < start + 10; k++) tick();
        bus.i_req = 0; bus.d_req = 0;
        if (gq.size() < start + 10) begin
            errors++; checks++;
            $display("FAIL burst_timeout: got %0d grants expected 10", gq.size() - start);
        end
        order = "";
        for (int k = start; k < gq.size() && k < start + 10; k++)
            order = {order, (gq[k] == OWN_I) ? "I" : "D"};
        chk_str("burst_order", order, "DDDDIDDDDI");
        for (int k = 0; k < 6; k++) tick();

        // reset while waiting for the memory response
        mem_auto = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        bus.i_req = 1; bus.i_addr = 32'h300;
        tick();
        bus.i_req = 0; bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_mem_req",  32'(bus.mem_req),  32'h0);
        chk("rstw_mem_addr", bus.mem_addr,      32'h0);
        chk("rstw_mem_be",   32'(bus.mem_be),   32'h0);
        chk("rstw_i_rdata",  bus.i_rdata,       32'h0);
        chk("rstw_d_rdata",  bus.d_rdata,       32'h0);
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.mem_rvalid = 0;
            cnt_a += int'(bus.i_rvalid) + int'(bus.d_rvalid);
        end
        chk("rstw_late_rvalid", 32'(cnt_a), 32'h0);

        // grant and response together in ISSUE
        mem_auto = 1; gnt_wait = 0; rv_delay = 0; w_cnt = 0; pend = 0; rsp_data = 32'h1234_5678;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h40;
        tick();
        chk("same_gnt", 32'(s_d_gnt), 32'h1);
        bus.d_req = 0;
        tick();
        chk("same_rvalid_c2", 32'(bus.d_rvalid), 32'h1);
        chk("same_rdata_c2",  bus.d_rdata,       32'h1234_5678);
        chk("same_req_c2",    32'(bus.mem_req),  32'h0);
        for (int k = 0; k < 4; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
